// File: rtl/gcm_view_pkg.sv
// rtl/gcm_view_pkg.sv - shared types and widths for the GCM result viewer
package gcm_view_pkg;

    typedef enum logic {VIEW_WAIT, VIEW_SHOW} view_state_t;

    localparam int BLOCK_BITS = 128;
    localparam int BYTE_IDX_W = 4;

endpackage

// File: rtl/gcm_result_viewer_rise_detect.sv
// rtl/gcm_result_viewer_rise_detect.sv - registered rising-edge detector
//
// Ports:
//   clk      in   clock
//   i_reset  in   synchronous active-high reset
//   i_d      in   level input
//   o_rise   out  high for the cycle where i_d is 1 and was 0 on the previous edge
//
// RESET_VAL sets the remembered previous level after reset; 1 means an input
// already high when reset releases does not count as an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = i_d;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_rise = i_d & ~prev_q;

endmodule

// File: rtl/gcm_result_viewer.sv
// rtl/gcm_result_viewer.sv - capture GCM ciphertext/tag and scroll byte pairs to the display
//
// Ports:
//   clk            in   system clock
//   i_reset        in   synchronous active-high reset
//   i_cipher_text  in   [0:127] live ciphertext, byte k = bits [8k:8k+7]
//   i_tag          in   [0:127] live tag, same byte ordering
//   i_tag_ready    in   tag valid level; first high after reset captures
//   i_step         in   debounced button level; rising edges advance the byte index
//   o_disp_word    out  {tag byte k, ciphertext byte k}
//   o_index        out  current byte index k
//   o_valid        out  high once a result has been captured
//
// Optional feature macro: GCM_RESULT_VIEW_AUTOSCROLL_EN adds a prescaler that
// advances the index every SCROLL_DIV cycles while showing a captured result.
module gcm_result_viewer
    import gcm_view_pkg::*;
#(
    parameter int SCROLL_DIV = 50000000
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic [0:BLOCK_BITS-1] i_cipher_text,
    input  logic [0:BLOCK_BITS-1] i_tag,
    input  logic                  i_tag_ready,
    input  logic                  i_step,
    output logic [15:0]           o_disp_word,
    output logic [3:0]            o_index,
    output logic                  o_valid
);

    view_state_t           state_q, state_d;
    logic [15:0]           disp_q, disp_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [0:BLOCK_BITS-1] ct_hold_q, ct_hold_d;
    logic [0:BLOCK_BITS-1] tag_hold_q, tag_hold_d;

    logic                  step_rise;
    logic                  tick;
    logic                  advance;
    logic [BYTE_IDX_W-1:0] next_idx;

    rise_detect #(.RESET_VAL(1'b1)) u_step_rise (
        .clk     (clk),
        .i_reset (i_reset),
        .i_d     (i_step),
        .o_rise  (step_rise)
    );

`ifdef GCM_RESULT_VIEW_AUTOSCROLL_EN
    localparam int PS_W = $clog2(SCROLL_DIV);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(SCROLL_DIV - 1);

    logic [PS_W-1:0] ps_q, ps_d;

    assign tick = (state_q == VIEW_SHOW) && (ps_q == PS_MAX);

    // Prescaler only runs while showing; any advance (manual or tick) restarts it.
    always_comb begin
        ps_d = '0;
        if (state_q == VIEW_SHOW && !advance) begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end
`else
    logic unused_scroll_div;
    assign unused_scroll_div = ^SCROLL_DIV;
    assign tick = 1'b0;
`endif

    // A step edge and a tick in the same cycle collapse into one advance.
    assign advance  = (state_q == VIEW_SHOW) && (step_rise || tick);
    assign next_idx = idx_q + BYTE_IDX_W'(1);

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q    <= VIEW_WAIT;
            disp_q     <= 16'h0000;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            ct_hold_q  <= '0;
            tag_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            ct_hold_q  <= ct_hold_d;
            tag_hold_q <= tag_hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == VIEW_WAIT && i_tag_ready) begin
            state_d = VIEW_SHOW;
        end
    end

    always_comb begin
        disp_d     = disp_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        ct_hold_d  = ct_hold_q;
        tag_hold_d = tag_hold_q;
        case (state_q)
            VIEW_WAIT: begin
                disp_d  = {i_tag[0:7], i_cipher_text[0:7]};
                idx_d   = '0;
                valid_d = 1'b0;
                if (i_tag_ready) begin
                    ct_hold_d  = i_cipher_text;
                    tag_hold_d = i_tag;
                    valid_d    = 1'b1;
                end
            end
            VIEW_SHOW: begin
                if (advance) begin
                    idx_d  = next_idx;
                    disp_d = {tag_hold_q[{next_idx, 3'b000} +: 8],
                              ct_hold_q[{next_idx, 3'b000} +: 8]};
                end
            end
            default: begin
                disp_d = disp_q;
            end
        endcase
    end

    assign o_disp_word = disp_q;
    assign o_index     = idx_q;
    assign o_valid     = valid_q;

endmodule

// File: tb/tb_gcm_result_viewer.sv
// tb/tb_gcm_result_viewer.sv - self-checking bench for gcm_result_viewer
module tb_gcm_result_viewer;

    logic           clk = 1'b0;
    logic           i_reset;
    logic [127:0]   i_cipher_text;
    logic [127:0]   i_tag;
    logic           i_tag_ready;
    logic           i_step;
    logic [15:0]    o_disp_word;
    logic [3:0]     o_index;
    logic           o_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         rst;
        logic         rdy;
        logic         stp;
        logic [127:0] tag;
        logic [127:0] ct;
        logic [15:0]  disp;
        logic [3:0]   idx;
        logic         vld;
    } vec_t;

    typedef struct {
        logic [15:0] disp;
        logic [3:0]  idx;
        logic        vld;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[7];

    localparam logic [127:0] TAG_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] CT_A  = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    localparam logic [127:0] TAG_B = 128'h0123456789ABCDEF0F1E2D3C4B5A6978;
    localparam logic [127:0] CT_B  = 128'hFEDCBA98765432101122334455667788;
    localparam logic [127:0] ONES  = {128{1'b1}};
    localparam logic [127:0] P_TAG = 128'hA5000000000000000000000000000000;
    localparam logic [127:0] P_CT  = 128'h3C000000000000000000000000000000;

    gcm_result_viewer #(.SCROLL_DIV(4)) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_cipher_text (i_cipher_text),
        .i_tag         (i_tag),
        .i_tag_ready   (i_tag_ready),
        .i_step        (i_step),
        .o_disp_word   (o_disp_word),
        .o_index       (o_index),
        .o_valid       (o_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte k sits at the leftmost end of the hex literal for k = 0.
    function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
        return v[127 - 8*k -: 8];
    endfunction

    function automatic logic [15:0] pair(input logic [127:0] t, input logic [127:0] c, input int k);
        return {byte_of(t, k), byte_of(c, k)};
    endfunction

    task automatic check_out(input string name);
        exp_t e;
        e = sb.pop_front();
        n_checks += 3;
        if (o_disp_word !== e.disp) begin
            n_fail++;
            $display("FAIL %s disp: got %h want %h", name, o_disp_word, e.disp);
        end
        if (o_index !== e.idx) begin
            n_fail++;
            $display("FAIL %s index: got %0d want %0d", name, o_index, e.idx);
        end
        if (o_valid !== e.vld) begin
            n_fail++;
            $display("FAIL %s valid: got %b want %b", name, o_valid, e.vld);
        end
    endtask

    task automatic cyc(input logic rst, input logic rdy, input logic stp,
                       input logic [127:0] tag, input logic [127:0] ct,
                       input logic [15:0] disp, input logic [3:0] idx,
                       input logic vld, input string name);
        exp_t e;
        @(negedge clk);
        i_reset       = rst;
        i_tag_ready   = rdy;
        i_step        = stp;
        i_tag         = tag;
        i_cipher_text = ct;
        e.disp = disp;
        e.idx  = idx;
        e.vld  = vld;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out(name);
    endtask

    initial begin
        i_reset = 1'b1; i_tag_ready = 1'b0; i_step = 1'b0;
        i_tag = '0; i_cipher_text = '0;

        tbl[0] = '{1'b1, 1'b0, 1'b0, P_TAG, P_CT, 16'h0000, 4'd0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, P_TAG, P_CT, 16'h0000, 4'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, P_TAG, P_CT, 16'hA53C, 4'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, TAG_A, CT_A, 16'h00F0, 4'd0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, ONES,  ONES, 16'h00F0, 4'd0, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0, ONES,  ONES, 16'h00F0, 4'd0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, ONES,  ONES, 16'h00F0, 4'd0, 1'b1};

        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].rst, tbl[i].rdy, tbl[i].stp, tbl[i].tag, tbl[i].ct,
                tbl[i].disp, tbl[i].idx, tbl[i].vld, $sformatf("vec%0d", i));
        end

`ifndef GCM_RESULT_VIEW_AUTOSCROLL_EN
        // Manual scroll through all 16 bytes and wrap back to 0.
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b0, 1'b0, 1'b1, ONES, ONES, pair(TAG_A, CT_A, k % 16), 4'(k % 16), 1'b1,
                $sformatf("step_hi%0d", k));
            cyc(1'b0, 1'b0, 1'b0, ONES, ONES, pair(TAG_A, CT_A, k % 16), 4'(k % 16), 1'b1,
                $sformatf("step_lo%0d", k));
            if (k == 15 && pair(TAG_A, CT_A, 15) != 16'hFF0F) begin
                n_fail++;
                $display("FAIL byte15_ref: got %h want ff0f", pair(TAG_A, CT_A, 15));
            end
        end
        // Held step: only the first edge counts.
        cyc(1'b0, 1'b0, 1'b1, ONES, ONES, pair(TAG_A, CT_A, 1), 4'd1, 1'b1, "hold_rise");
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b1, ONES, ONES, pair(TAG_A, CT_A, 1), 4'd1, 1'b1, "hold_high");

        // Walk to index 7, then reset together with tag_ready.
        for (int k = 2; k <= 7; k++) begin
            cyc(1'b0, 1'b0, 1'b0, ONES, ONES, pair(TAG_A, CT_A, k - 1), 4'(k - 1), 1'b1, "walk_lo");
            cyc(1'b0, 1'b0, 1'b1, ONES, ONES, pair(TAG_A, CT_A, k), 4'(k), 1'b1, "walk_hi");
        end
        cyc(1'b1, 1'b1, 1'b0, TAG_B, CT_B, 16'h0000, 4'd0, 1'b0, "mid_reset");
        cyc(1'b0, 1'b1, 1'b0, TAG_B, CT_B, pair(TAG_B, CT_B, 0), 4'd0, 1'b1, "recapture");
        cyc(1'b0, 1'b0, 1'b1, ONES, ONES, pair(TAG_B, CT_B, 1), 4'd1, 1'b1, "recap_step");

        // Step held high through reset release and capture.
        cyc(1'b1, 1'b0, 1'b1, TAG_A, CT_A, 16'h0000, 4'd0, 1'b0, "held_rst");
        cyc(1'b0, 1'b0, 1'b1, TAG_A, CT_A, pair(TAG_A, CT_A, 0), 4'd0, 1'b0, "held_wait");
        cyc(1'b0, 1'b1, 1'b1, TAG_A, CT_A, pair(TAG_A, CT_A, 0), 4'd0, 1'b1, "held_cap");
        cyc(1'b0, 1'b0, 1'b1, ONES, ONES, pair(TAG_A, CT_A, 0), 4'd0, 1'b1, "held_show");
        cyc(1'b0, 1'b0, 1'b0, ONES, ONES, pair(TAG_A, CT_A, 0), 4'd0, 1'b1, "held_fall");
        cyc(1'b0, 1'b0, 1'b1, ONES, ONES, pair(TAG_A, CT_A, 1), 4'd1, 1'b1, "held_rerise");
`else
        // Capture happened at tbl[3]; three show cycles since then. Model the
        // divide-by-4 scroll: counter after capture is 3, index 0.
        begin
            int ps  = 3;
            int idx = 0;
            for (int c = 0; c < 20; c++) begin
                logic stp;
                logic adv;
                // Step edge lands on the tick edge at c == 8 (ps == 3).
                stp = (c == 8);
                adv = (ps == 3) || stp;
                if (adv) begin
                    idx = (idx + 1) % 16;
                    ps  = 0;
                end else begin
                    ps = ps + 1;
                end
                cyc(1'b0, 1'b0, stp, ONES, ONES, pair(TAG_A, CT_A, idx), 4'(idx), 1'b1,
                    $sformatf("auto%0d", c));
            end
        end
        cyc(1'b1, 1'b1, 1'b0, TAG_B, CT_B, 16'h0000, 4'd0, 1'b0, "auto_reset");
        cyc(1'b0, 1'b1, 1'b0, TAG_B, CT_B, pair(TAG_B, CT_B, 0), 4'd0, 1'b1, "auto_recap");
        for (int c = 1; c <= 4; c++)
            cyc(1'b0, 1'b0, 1'b0, ONES, ONES, pair(TAG_B, CT_B, c / 4), 4'(c / 4), 1'b1,
                $sformatf("auto_recap%0d", c));
`endif

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        n_checks++;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcm_result_viewer.md
# gcm_result_viewer

Result-capture and byte-scroll stage between `gcm_aes` and the seven-segment `display` driver. Waits for the first `i_tag_ready` after reset, freezes the 128-bit ciphertext and 128-bit tag, then presents one byte pair {tag byte k, ciphertext byte k} per step as a 16-bit display word. Stepping is by a push-button edge or, optionally, by an internal scroll timer. This makes the whole result inspectable on four digits.

## Interface
- `SCROLL_DIV`, default 50000000: clock cycles per automatic byte advance; legal range ≥ 2; used only with the autoscroll feature.
- `clk`  in  1  system clock (`clk_out` of `clk_gen`).
- `i_reset`  in  1  reset; one clock; reset is synchronous and active-high.
- `i_cipher_text`  in  [0:127]  live ciphertext from `gcm_aes`; byte k = bits [8k:8k+7].
- `i_tag`  in  [0:127]  live tag from `gcm_aes`; same byte ordering.
- `i_tag_ready`  in  1  level, high when the tag is valid.
- `i_step`  in  1  manual advance, already debounced, level; only rising edges count.
- `o_disp_word`  out  16  {tag byte k, ciphertext byte k}; goes to `display.i_x`.
- `o_index`  out  4  current byte index k.
- `o_valid`  out  1  high once a result is captured.

## Operation
- FSM states:
  - `VIEW_WAIT` (reset state).
  - `VIEW_SHOW` (terminal until reset).
- **VIEW_WAIT**
  - Each cycle `o_disp_word` <= {i_tag[0:7], i_cipher_text[0:7]} (live pass-through).
  - `o_index` = 0, `o_valid` = 0.
  - Steps and timer are ignored; the prescaler is held at 0.
- **VIEW_WAIT -> VIEW_SHOW**: on the first edge where `i_tag_ready` = 1.
  - Load the hold registers `ct_hold` <= `i_cipher_text` and `tag_hold` <= `i_tag`.
  - `o_disp_word` <= {i_tag[0:7], i_cipher_text[0:7]}.
  - `o_index` <= 0, `o_valid` <= 1.
- **VIEW_SHOW**
  - Hold registers are frozen. Later `i_tag_ready` activity and input changes are ignored.
  - An advance event moves k to k+1 mod 16 (15 wraps to 0).
  - On an advance, `o_index` and `o_disp_word` = {tag_hold[8k':+8], ct_hold[8k':+8]} update on the same edge, using the new k'.
- **Step edge**: `i_step` = 1 with `step_prev` = 0. `step_prev` is a register that resets to 1, so a button held through reset does not advance.
- **Simultaneous step edge and timer tick**: exactly one advance.
- **`i_reset` in any state, including mid-scroll**: all registers return to reset values on that edge, and the FSM is back in `VIEW_WAIT` the next cycle. If `i_reset` and `i_tag_ready` are both high, reset wins.

## Timing
- Reset values:
  - `o_disp_word` = 16'h0000, `o_index` = 0, `o_valid` = 0.
  - `ct_hold` = 0, `tag_hold` = 0.
  - prescaler = 0, `step_prev` = 1.
- Every output is registered. There is no combinational path from inputs to outputs.
- Capture latency: `i_tag_ready` sampled high at edge N gives `o_valid` = 1 and byte 0 of the captured data after edge N.
- Step latency: step edge sampled at edge N gives the new `o_index` and `o_disp_word` after edge N.
- Prescaler:
  - Counts 0..SCROLL_DIV-1 in `VIEW_SHOW` only.
  - Generates a tick when it reaches SCROLL_DIV-1, then wraps to 0.
  - Clears to 0 on any manual advance.
  - First auto advance comes SCROLL_DIV cycles after capture.
- Prescaler width = $clog2(SCROLL_DIV).

## Configuration
- Macro: `GCM_RESULT_VIEW_AUTOSCROLL_EN`.
- Defined: prescaler present. Advance events are step edges OR timer ticks.
- Undefined: no prescaler logic and `SCROLL_DIV` is unused. Advance events are step edges only; k stays fixed without button presses.

## Structure
- Package `gcm_view_pkg` holds:
  - `typedef enum logic {VIEW_WAIT, VIEW_SHOW} view_state_t`
  - `localparam BLOCK_BITS = 128`
  - `localparam BYTE_IDX_W = 4`
- One natural sub-module: `rise_detect`. It takes a one-bit registered rising-edge detector with a configurable reset value (1 here) and is used for `i_step`.
- Byte select is an indexed part-select; no separate mux module.

## Test plan
- **Reset and pass-through**: hold `i_reset` = 1 for 2 cycles, then apply tag byte 0 = 8'hA5 and ct byte 0 = 8'h3C with `i_tag_ready` = 0. Expect `o_disp_word` = 16'h0000 during reset, 16'hA53C one cycle after release, `o_valid` = 0.
- **Capture and freeze**: tag = 128'h00112233...FF, ct = 128'hF0E1D2...0F; pulse `i_tag_ready` for 1 cycle, then change both inputs to all-ones. Expect `o_valid` = 1, `o_index` = 0, `o_disp_word` = 16'h00F0, stable.
- **Manual scroll and wrap**: after capture, apply 16 rising edges on `i_step` (macro undefined). Expect `o_index` 1..15 then 0; at k = 15, `o_disp_word` = {tag byte 15, ct byte 15}; holding `i_step` high gives no further advance.
- **Autoscroll**: macro defined, `SCROLL_DIV` = 4, no steps. Expect `o_index` to increment every 4 cycles after capture. A step edge arriving in the same cycle as a tick advances by exactly 1, and the next tick comes 4 cycles later.
- **Reset mid-scroll**: at `o_index` = 7, assert `i_reset` for 1 cycle while `i_tag_ready` = 1. Expect all outputs back to reset values. The next cycle with `i_tag_ready` = 1 and `i_reset` = 0 recaptures, giving `o_valid` = 1 and `o_index` = 0.
- **Step held through reset**: hold `i_step` = 1 across reset release and the subsequent capture. Expect no advance until `i_step` falls and rises again.
